sbox_row_inverter: RTL and testbench

- Inverse-lookup companion to the DES S-box ROMs: for a given row and 4-bit S-box output, it returns the column that produced that output.
- Each DES S-box row is a permutation of 0..15, so the per-row inverse is well defined.
- Forward table contents are written in through a load port. A build pass scans them, fills the inverse table and checks that every row is a permutation.
- Lookups are then served through a valid/ready handshake. Used by the decrypt-side key-recovery/debug path and by the S-box self-check logic.

---
 rtl/sbox_row_inverter.sv | 156 +++++++++++++++
 tb/tb_sbox_row_inverter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_row_inverter.sv
// Per-row inverse of a loadable DES S-box table: a build pass derives col = inv[{row,val}]
// from the forward contents and flags rows that are not permutations; lookups use valid/ready.
module sbox_row_inverter #(
    parameter int ROW_W     = 2,
    parameter int COL_W     = 4,
    parameter int TBL_DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [ROW_W+COL_W-1:0] load_addr,
    input  logic [COL_W-1:0]       load_data,
    input  logic                   build_start,
    output logic                   busy,
    output logic                   table_ok,
    output logic                   table_err,
    input  logic                   q_valid,
    output logic                   q_ready,
    input  logic [ROW_W-1:0]       q_row,
    input  logic [COL_W-1:0]       q_val,
    output logic                   r_valid,
    output logic [ROW_W-1:0]       r_row,
    output logic [COL_W-1:0]       r_col
);

    localparam int AW = ROW_W + COL_W;

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        CHECK,
        READY,
        ERR
    } state_t;

    state_t               state_q;
    logic                 busy_q;
    logic                 table_ok_q;
    logic                 table_err_q;
    logic                 r_valid_q;
    logic [ROW_W-1:0]     r_row_q;
    logic [COL_W-1:0]     r_col_q;

    logic [COL_W-1:0]     fwd_q [TBL_DEPTH];
    logic [COL_W-1:0]     inv_q [TBL_DEPTH];
    logic [TBL_DEPTH-1:0] seen_q;
    logic [AW-1:0]        idx_q;
    logic                 dup_q;

    logic                 cmd_state;
    logic                 load_acc;
    logic                 build_acc;
    logic                 q_acc;
    logic [COL_W-1:0]     build_val;
    logic [AW-1:0]        build_key;
    logic                 build_dup;
    logic                 inv_we;

    always_comb begin
        cmd_state = (state_q == IDLE) || (state_q == READY) || (state_q == ERR);
        load_acc  = load_en && cmd_state;
        build_acc = build_start && cmd_state;
        q_ready   = (state_q == READY) && !load_en && !build_start;
        q_acc     = q_valid && q_ready;
        build_val = fwd_q[idx_q];
        build_key = {idx_q[AW-1:COL_W], build_val};
        build_dup = seen_q[build_key];
        inv_we    = (state_q == BUILD) && !build_dup;
    end

    // Table storage carries no reset; only the bookkeeping around it does.
    always_ff @(posedge clk) begin
        if (!rst && load_acc) begin
            fwd_q[load_addr] <= load_data;
        end
        if (!rst && inv_we) begin
            inv_q[build_key] <= idx_q[COL_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            table_ok_q  <= 1'b0;
            table_err_q <= 1'b0;
            r_valid_q   <= 1'b0;
            r_row_q     <= '0;
            r_col_q     <= '0;
            seen_q      <= '0;
            idx_q       <= '0;
            dup_q       <= 1'b0;
        end else begin
            r_valid_q <= q_acc;
            if (q_acc) begin
                r_row_q <= q_row;
                r_col_q <= inv_q[{q_row, q_val}];
            end

            case (state_q)
                IDLE, READY, ERR: begin
                    // Build wins over a same-cycle load; the write lands before idx 0 is read.
                    if (build_acc) begin
                        seen_q      <= '0;
                        idx_q       <= '0;
                        dup_q       <= 1'b0;
                        table_ok_q  <= 1'b0;
                        table_err_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= BUILD;
                    end else if (load_acc) begin
                        table_ok_q  <= 1'b0;
                        table_err_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                BUILD: begin
                    if (build_dup) begin
                        dup_q <= 1'b1;
                    end else begin
                        seen_q[build_key] <= 1'b1;
                    end
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == {AW{1'b1}}) begin
                        state_q <= CHECK;
                    end
                end

                CHECK: begin
                    busy_q <= 1'b0;
                    if (!dup_q && (&seen_q)) begin
                        table_ok_q <= 1'b1;
                        state_q    <= READY;
                    end else begin
                        table_err_q <= 1'b1;
                        state_q     <= ERR;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign table_ok  = table_ok_q;
    assign table_err = table_err_q;
    assign r_valid   = r_valid_q;
    assign r_row     = r_row_q;
    assign r_col     = r_col_q;

endmodule

// File: tb/tb_sbox_row_inverter.sv
// Directed bench for sbox_row_inverter: DES S6 build, lookups checked through a scoreboard queue.
module tb_sbox_row_inverter;

    logic       clk;
    logic       rst;
    logic       load_en;
    logic [5:0] load_addr;
    logic [3:0] load_data;
    logic       build_start;
    logic       busy;
    logic       table_ok;
    logic       table_err;
    logic       q_valid;
    logic       q_ready;
    logic [1:0] q_row;
    logic [3:0] q_val;
    logic       r_valid;
    logic [1:0] r_row;
    logic [3:0] r_col;

    typedef struct {
        logic [1:0] row;
        logic [3:0] col;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] model [64];
    logic [3:0] s6 [64];
    int         passed = 0;
    int         total  = 0;

    sbox_row_inverter #(
        .ROW_W(2),
        .COL_W(4),
        .TBL_DEPTH(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .build_start(build_start),
        .busy       (busy),
        .table_ok   (table_ok),
        .table_err  (table_err),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .q_row      (q_row),
        .q_val      (q_val),
        .r_valid    (r_valid),
        .r_row      (r_row),
        .r_col      (r_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [3:0] model_inv(input logic [1:0] r, input logic [3:0] v);
        logic [5:0] a;
        for (int c = 0; c < 16; c++) begin
            a = {r, 4'(c)};
            if (model[a] == v) return 4'(c);
        end
        return 4'd0;
    endfunction

    // Results are popped in acceptance order.
    always @(negedge clk) begin
        if (!rst && r_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_r_valid", r_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("r_row", r_row, e.row);
                chk("r_col", r_col, e.col);
            end
        end
    end

    task automatic load(input logic [5:0] a, input logic [3:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        model[a]  = d;
        @(posedge clk); #1;
        load_en   = 1'b0;
    endtask

    task automatic lookup(input logic [1:0] r, input logic [3:0] v, input logic [3:0] c);
        exp_t e;
        q_valid = 1'b1;
        q_row   = r;
        q_val   = v;
        #1;
        chk("q_ready_ready", q_ready, 1);
        e.row = r;
        e.col = c;
        sb.push_back(e);
        @(posedge clk); #1;
        chk("r_valid_pulse", r_valid, 1);
    endtask

    // Caller may pre-set load_en/load_addr/load_data for a same-cycle write.
    task automatic build_and_check(input string tag, input bit exp_ok, input bit poke);
        int hi;
        hi = 0;
        build_start = 1'b1;
        @(posedge clk); #1;
        build_start = 1'b0;
        load_en     = 1'b0;
        for (int i = 1; i <= 65; i++) begin
            if (poke && i == 11) begin
                load_en     = 1'b0;
                build_start = 1'b0;
                q_valid     = 1'b0;
            end
            if (busy === 1'b1) hi++;
            if (poke && i == 10) begin
                load_en     = 1'b1;
                load_addr   = 6'd0;
                load_data   = 4'd1;
                build_start = 1'b1;
                q_valid     = 1'b1;
                q_row       = 2'd0;
                q_val       = 4'd0;
                #1;
                chk({tag, "_q_ready_busy"}, q_ready, 0);
            end
            @(posedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, hi, 65);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_table_ok"}, table_ok, exp_ok);
        chk({tag, "_table_err"}, table_err, !exp_ok);
    endtask

    task automatic sweep();
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < 16; v++) begin
                lookup(2'(r), 4'(v), model_inv(2'(r), 4'(v)));
            end
        end
        q_valid = 1'b0;
        @(posedge clk); #1;
        chk("sweep_r_valid_low", r_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s6 = '{12, 1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
               10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
                9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
                4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13};
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        build_start = 1'b0; q_valid = 1'b0; q_row = '0; q_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_table_ok", table_ok, 0);
        chk("rst_table_err", table_err, 0);
        chk("rst_q_ready", q_ready, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_row", r_row, 0);
        chk("rst_r_col", r_col, 0);
        rst = 1'b0;

        // Queries with no table are never accepted.
        q_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("idle_q_ready", q_ready, 0);
            @(posedge clk); #1;
            chk("idle_r_valid", r_valid, 0);
            chk("idle_busy", busy, 0);
        end
        q_valid = 1'b0;

        for (int a = 0; a < 64; a++) load(6'(a), s6[a]);
        build_and_check("s6", 1'b1, 1'b0);

        lookup(2'd0, 4'd12, 4'd0);
        lookup(2'd0, 4'd0, 4'd8);
        lookup(2'd1, 4'd0, 4'd12);
        q_valid = 1'b0;
        @(posedge clk); #1;
        chk("burst_end_r_valid", r_valid, 0);
        @(posedge clk); #1;
        chk("hold_r_row", r_row, 1);
        chk("hold_r_col", r_col, 12);

        sweep();

        // Duplicate in row 0; the load itself invalidates the good table.
        load(6'd1, 4'd12);
        chk("inval_table_ok", table_ok, 0);
        #1;
        chk("inval_q_ready", q_ready, 0);
        build_and_check("dup", 1'b0, 1'b0);
        q_valid = 1'b1;
        q_row = 2'd0;
        q_val = 4'd12;
        #1;
        chk("err_q_ready", q_ready, 0);
        @(posedge clk); #1;
        chk("err_r_valid", r_valid, 0);
        q_valid = 1'b0;

        // Same-cycle load and build: build must see the corrected entry.
        load_en   = 1'b1;
        load_addr = 6'd1;
        load_data = 4'd1;
        model[1]  = 4'd1;
        build_and_check("fix", 1'b1, 1'b0);
        lookup(2'd0, 4'd1, 4'd1);
        lookup(2'd0, 4'd12, 4'd0);
        q_valid = 1'b0;
        @(posedge clk); #1;

        // Reset in cycle T+30 of a build.
        build_start = 1'b1;
        @(posedge clk); #1;
        build_start = 1'b0;
        repeat (29) begin
            @(posedge clk); #1;
        end
        chk("midbuild_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_table_ok", table_ok, 0);
        chk("midrst_table_err", table_err, 0);

        // Load/build/query pokes during the build are ignored.
        build_and_check("rebuild", 1'b1, 1'b1);
        sweep();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
